// File: rtl/decoder_nto2n_scan_if.sv
// Bus bundle for decoder_nto2n_scan: control/select inputs and registered decode outputs.
// The master drives the controls; the slave is the decoder itself.
interface decoder_nto2n_scan_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    logic                    en;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic                    load;
    logic [DWELL_W-1:0]      dwell;
    logic [(1<<SEL_W)-1:0]   dout;
    logic [SEL_W-1:0]        idx;
    logic                    wrap;

    modport master (
        output en, mode, sel, load, dwell,
        input  dout, idx, wrap
    );

    modport slave (
        input  en, mode, sel, load, dwell,
        output dout, idx, wrap
    );
endinterface

// File: rtl/decoder_nto2n_scan.sv
// N-to-2**N decoder with registered one-hot output.
// Decodes sel directly, or auto-scans every output line with a programmable dwell per step.
module decoder_nto2n_scan #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    decoder_nto2n_scan_if.slave   bus
);
    localparam int OUT_W = 1 << SEL_W;

    logic [SEL_W-1:0]   idx_reg,   idx_next;
    logic [OUT_W-1:0]   dout_reg,  dout_next;
    logic               wrap_reg,  wrap_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic [DWELL_W-1:0] cnt_reg,   cnt_next;
    logic               dec_en;

    always_comb begin
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        dwell_next = dwell_reg;
        wrap_next  = 1'b0;
        dec_en     = 1'b0;

        // load acts even while disabled, and beats the step condition
        if (bus.load) begin
            dwell_next = bus.dwell;
            cnt_next   = '0;
        end

        if (bus.en) begin
            dec_en = 1'b1;
            if (!bus.mode) begin
                idx_next = bus.sel;
                cnt_next = '0;
            end else if (!bus.load) begin
                // compare before incrementing so the counter tops out at dwell_reg
                if (cnt_reg == dwell_reg) begin
                    cnt_next  = '0;
                    idx_next  = idx_reg + 1'b1;
                    wrap_next = (idx_reg == {SEL_W{1'b1}});
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end
    end

    // decode from idx_next so dout and idx always land on the same edge
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign dout_next[gi] = dec_en && (idx_next == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            dout_reg  <= '0;
            wrap_reg  <= 1'b0;
            dwell_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            idx_reg   <= idx_next;
            dout_reg  <= dout_next;
            wrap_reg  <= wrap_next;
            dwell_reg <= dwell_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.dout = dout_reg;
    assign bus.idx  = idx_reg;
    assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Directed bench for decoder_nto2n_scan: a 2-bit instance for most scenarios,
// and a 3-bit instance with a 2-bit dwell for full rotation and maximum-dwell checks.
module tb_decoder_nto2n_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    decoder_nto2n_scan_if #(.SEL_W(2), .DWELL_W(8)) b2 ();
    decoder_nto2n_scan_if #(.SEL_W(3), .DWELL_W(2)) b3 ();

    decoder_nto2n_scan #(.SEL_W(2), .DWELL_W(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    decoder_nto2n_scan #(.SEL_W(3), .DWELL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        $display("reset: dut2 dout=%b idx=%0d wrap=%b dut3 dout=%b idx=%0d", b2.dout, b2.idx, b2.wrap, b3.dout, b3.idx);
        vecs++; if (b2.dout !== 4'b0000) begin errs++; $display("FAIL reset_dout2: got %b expected 0000", b2.dout); end
        vecs++; if (b2.idx !== 2'd0) begin errs++; $display("FAIL reset_idx2: got %0d expected 0", b2.idx); end
        vecs++; if (b2.wrap !== 1'b0) begin errs++; $display("FAIL reset_wrap2: got %b expected 0", b2.wrap); end
        vecs++; if (b3.dout !== 8'h00) begin errs++; $display("FAIL reset_dout3: got %b expected 00000000", b3.dout); end
        vecs++; if (b3.idx !== 3'd0) begin errs++; $display("FAIL reset_idx3: got %0d expected 0", b3.idx); end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        logic [3:0] exp_dout [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        b2.en = 1'b1; b2.mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            b2.sel = 2'(s);
            if (s == 1) begin
                #1;
                vecs++; if (b2.dout !== 4'b0001) begin errs++; $display("FAIL direct_latency: got %b expected 0001", b2.dout); end
            end
            tick();
            $display("direct: sel=%0d dout=%b idx=%0d wrap=%b", s, b2.dout, b2.idx, b2.wrap);
            vecs++; if (b2.dout !== exp_dout[s]) begin errs++; $display("FAIL direct_dout: got %b expected %b", b2.dout, exp_dout[s]); end
            vecs++; if (b2.idx !== 2'(s)) begin errs++; $display("FAIL direct_idx: got %0d expected %0d", b2.idx, s); end
            vecs++; if (b2.wrap !== 1'b0) begin errs++; $display("FAIL direct_wrap: got %b expected 0", b2.wrap); end
        end
    endtask

    task automatic test_scan();
        int exp_idx [15] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
        logic [3:0] exp_dout;
        b2.sel = 2'd0;
        tick();
        b2.load = 1'b1; b2.dwell = 8'd2;
        tick();
        b2.load = 1'b0; b2.mode = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            exp_dout = 4'b0001 << exp_idx[k];
            $display("scan: edge=%0d dout=%b idx=%0d wrap=%b", k + 1, b2.dout, b2.idx, b2.wrap);
            vecs++; if (b2.idx !== 2'(exp_idx[k])) begin errs++; $display("FAIL scan_idx: edge %0d got %0d expected %0d", k + 1, b2.idx, exp_idx[k]); end
            vecs++; if (b2.dout !== exp_dout) begin errs++; $display("FAIL scan_dout: edge %0d got %b expected %b", k + 1, b2.dout, exp_dout); end
            vecs++; if (b2.wrap !== (k == 11)) begin errs++; $display("FAIL scan_wrap: edge %0d got %b expected %b", k + 1, b2.wrap, (k == 11)); end
        end
    endtask

    task automatic test_en_drop();
        int exp_pre [4] = '{1, 1, 2, 2};
        int exp_post [3] = '{2, 3, 3};
        for (int k = 0; k < 4; k++) begin
            tick();
            $display("pre_drop: dout=%b idx=%0d", b2.dout, b2.idx);
            vecs++; if (b2.idx !== 2'(exp_pre[k])) begin errs++; $display("FAIL pre_drop_idx: got %0d expected %0d", b2.idx, exp_pre[k]); end
        end
        b2.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            $display("en_drop: dout=%b idx=%0d wrap=%b", b2.dout, b2.idx, b2.wrap);
            vecs++; if (b2.dout !== 4'b0000) begin errs++; $display("FAIL drop_dout: got %b expected 0000", b2.dout); end
            vecs++; if (b2.idx !== 2'd2) begin errs++; $display("FAIL drop_idx: got %0d expected 2", b2.idx); end
            vecs++; if (b2.wrap !== 1'b0) begin errs++; $display("FAIL drop_wrap: got %b expected 0", b2.wrap); end
        end
        b2.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("resume: dout=%b idx=%0d", b2.dout, b2.idx);
            vecs++; if (b2.idx !== 2'(exp_post[k])) begin errs++; $display("FAIL resume_idx: got %0d expected %0d", b2.idx, exp_post[k]); end
            vecs++; if (b2.dout !== (4'b0001 << exp_post[k])) begin errs++; $display("FAIL resume_dout: got %b expected %b", b2.dout, (4'b0001 << exp_post[k])); end
        end
    endtask

    task automatic test_async_reset();
        int exp_idx [4] = '{1, 2, 3, 0};
        #3 rst = 1'b1;
        #1;
        $display("async_rst: dout=%b idx=%0d wrap=%b", b2.dout, b2.idx, b2.wrap);
        vecs++; if (b2.dout !== 4'b0000) begin errs++; $display("FAIL async_rst_dout: got %b expected 0000", b2.dout); end
        vecs++; if (b2.idx !== 2'd0) begin errs++; $display("FAIL async_rst_idx: got %0d expected 0", b2.idx); end
        vecs++; if (b2.wrap !== 1'b0) begin errs++; $display("FAIL async_rst_wrap: got %b expected 0", b2.wrap); end
        tick();
        rst = 1'b0;
        // dwell_reg is back to 0, so the scan steps on every edge from idx 0
        for (int k = 0; k < 4; k++) begin
            tick();
            $display("restart: dout=%b idx=%0d wrap=%b", b2.dout, b2.idx, b2.wrap);
            vecs++; if (b2.idx !== 2'(exp_idx[k])) begin errs++; $display("FAIL restart_idx: got %0d expected %0d", b2.idx, exp_idx[k]); end
            vecs++; if (b2.wrap !== (k == 3)) begin errs++; $display("FAIL restart_wrap: got %b expected %b", b2.wrap, (k == 3)); end
        end
    endtask

    task automatic test_load_on_step();
        int exp_idx [5] = '{0, 0, 1, 1, 2};
        b2.load = 1'b1; b2.dwell = 8'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            b2.load = 1'b0;
            $display("load_step: dout=%b idx=%0d", b2.dout, b2.idx);
            vecs++; if (b2.idx !== 2'(exp_idx[k])) begin errs++; $display("FAIL load_step_idx: edge %0d got %0d expected %0d", k + 1, b2.idx, exp_idx[k]); end
            vecs++; if (b2.dout !== (4'b0001 << exp_idx[k])) begin errs++; $display("FAIL load_step_dout: got %b expected %b", b2.dout, (4'b0001 << exp_idx[k])); end
        end
    endtask

    task automatic test_rotate8();
        logic [7:0] exp_dout;
        b3.en = 1'b1; b3.mode = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_dout = 8'h01 << (k % 8);
            $display("rotate8: edge=%0d dout=%b idx=%0d wrap=%b", k, b3.dout, b3.idx, b3.wrap);
            vecs++; if (b3.dout !== exp_dout) begin errs++; $display("FAIL rotate8_dout: edge %0d got %b expected %b", k, b3.dout, exp_dout); end
            vecs++; if (b3.wrap !== ((k % 8) == 0)) begin errs++; $display("FAIL rotate8_wrap: edge %0d got %b expected %b", k, b3.wrap, ((k % 8) == 0)); end
        end
    endtask

    task automatic test_max_dwell();
        b3.load = 1'b1; b3.dwell = 2'd3;
        tick();
        b3.load = 1'b0;
        vecs++; if (b3.idx !== 3'd0) begin errs++; $display("FAIL max_dwell_load_idx: got %0d expected 0", b3.idx); end
        for (int j = 1; j <= 12; j++) begin
            tick();
            $display("max_dwell: edge=%0d dout=%b idx=%0d", j, b3.dout, b3.idx);
            vecs++; if (b3.idx !== 3'(j / 4)) begin errs++; $display("FAIL max_dwell_idx: edge %0d got %0d expected %0d", j, b3.idx, j / 4); end
        end
    endtask

    initial begin
        b2.en = 1'b0; b2.mode = 1'b0; b2.sel = '0; b2.load = 1'b0; b2.dwell = '0;
        b3.en = 1'b0; b3.mode = 1'b0; b3.sel = '0; b3.load = 1'b0; b3.dwell = '0;
        test_reset();
        test_direct();
        test_scan();
        test_en_drop();
        test_async_reset();
        test_load_on_step();
        test_rotate8();
        test_max_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/decoder_nto2n_scan.md
DECODER_NTO2N_SCAN -- requirements
Module: decoder_nto2n_scan

Interface
REQ-001 Parameter SEL_W, default 2: select width; output width is OUT_W = 2**SEL_W, legal range 1..6.
REQ-002 Parameter DWELL_W, default 8: width of the scan dwell register and counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  output enable; 0 forces dout to all-zero on the next edge.
REQ-006 mode  input  1  0 = direct decode of sel; 1 = auto-scan of all outputs.
REQ-007 sel  input  SEL_W  line select, used in direct mode only.
REQ-008 load  input  1  single-cycle strobe that captures dwell into the dwell register.
REQ-009 dwell  input  DWELL_W  dwell value; each scan step lasts dwell+1 cycles.
REQ-010 dout  output  OUT_W  registered decoded output, one-hot or all-zero.
REQ-011 idx  output  SEL_W  registered index of the currently selected line.
REQ-012 wrap  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-013 The block SHALL hold the following internal state: dwell_reg (DWELL_W bits) and dwell_cnt (DWELL_W bits).
REQ-014 Direct mode (mode=0, en=1): on each edge, idx SHALL be loaded with sel and dout with 1<<sel; latency sel->dout is 1 cycle.
REQ-015 Direct mode: dwell_cnt SHALL be held at 0 and wrap SHALL be 0.
REQ-016 Scan mode (mode=1, en=1), dwell_cnt<dwell_reg: dwell_cnt SHALL increment and idx SHALL hold.
REQ-017 Scan mode (mode=1, en=1), dwell_cnt==dwell_reg:
- dwell_cnt SHALL clear to 0.
- idx SHALL advance by 1 modulo OUT_W.
REQ-018 Scan mode: dout SHALL equal the one-hot of the next idx value, registered in the same edge, so that dout and idx always agree.
REQ-019 wrap SHALL be 1 for exactly the cycle after idx steps from OUT_W-1 to 0, and 0 otherwise.
REQ-020 Direct-to-scan switch: scanning SHALL start from the current idx with dwell_cnt=0, and no wrap pulse SHALL be issued on the switch.
REQ-021 Scan-to-direct switch: direct decode of sel SHALL take effect on the same edge.
REQ-022 en=0:
- dout SHALL be 0 and wrap SHALL be 0 on the next edge.
- idx, dwell_cnt and dwell_reg SHALL hold, except that load still applies.
- When en returns to 1, operation SHALL resume from the held state.
REQ-023 load=1:
- dwell_reg SHALL be loaded with dwell and dwell_cnt SHALL clear to 0 on that edge.
- idx SHALL NOT advance on that edge.
- load SHALL take priority over the step condition.
REQ-024 dwell_reg=0 in scan mode: idx SHALL advance every cycle.
REQ-025 dwell_reg at its maximum value: each step SHALL last 2**DWELL_W cycles, and the counter SHALL NOT overflow.
REQ-026 dout SHALL never have more than one bit set in any cycle.

Reset
REQ-027 While rst=1, the following SHALL be 0 immediately, without waiting for clk: dout, idx, wrap, dwell_reg and dwell_cnt.
REQ-028 Reset asserted mid-scan SHALL abort the current step; after release, a scan SHALL restart at idx=0 with dwell_reg=0.
REQ-029 On the first edge after rst deasserts, the block SHALL behave according to en, mode and the other inputs, with no extra latency.

Verification
REQ-030 Direct mode, SEL_W=2, en=1, sel stepped 0,1,2,3 -> dout = 0001, 0010, 0100, 1000, each one cycle after sel, and idx = sel.
REQ-031 Scan mode, load with dwell=2, then mode=1 -> idx steps every 3 cycles (0,1,2,3,0), and wrap is high for exactly 1 cycle when idx returns to 0.
REQ-032 Scan mode, dwell_reg=0, SEL_W=3 -> dout rotates 00000001 through 10000000 on consecutive cycles, and wrap is high every 8th cycle.
REQ-033 en dropped for 5 cycles mid-scan at idx=2 -> dout=0 during the drop; on re-enable, scanning resumes from idx=2 with the dwell count preserved.
REQ-034 rst pulsed asynchronously between edges during a scan with idx=3 -> dout, idx and wrap read 0 before the next edge; scanning restarts at idx=0.
REQ-035 load asserted on the cycle where dwell_cnt==dwell_reg -> idx does not advance, the new dwell is used, and dwell_cnt restarts at 0.
